// File: rtl/ovr_i_monitor.sv
// ovr_i_monitor: multi-channel blanked, period-qualified over-current shutdown with latch or bounded auto-retry recovery
module ovr_i_monitor #(
  parameter int NUM_CH        = 2,
  parameter int PWM_W         = 11,
  parameter int BLANK_START   = 32,
  parameter int BLANK_END     = 160,
  parameter int FAULT_THRESH  = 30,
  parameter int RETRY_MODE    = 0,
  parameter int RETRY_PERIODS = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PWM_synch,
  input  logic [PWM_W-1:0]  pwm_cnt,
  input  logic [NUM_CH-1:0] OVR_I,
  input  logic              clr_fault,
  output logic              OVR_I_shtdwn,
  output logic              ovr_I_blank,
  output logic [NUM_CH-1:0] fault_ch,
  output logic              locked,
  output logic [3:0]        retry_cnt
);
  localparam logic [PWM_W-1:0] B_START = PWM_W'(BLANK_START);
  localparam logic [PWM_W-1:0] B_END   = PWM_W'(BLANK_END);
  localparam logic [7:0]       TH      = 8'(FAULT_THRESH);
  localparam logic [15:0]      RP_LAST = 16'(RETRY_PERIODS - 1);
  localparam logic [3:0]       MAX_R   = 4'(MAX_RETRY);
  typedef enum logic [1:0] {RUN, SHTDWN, LOCKED} state_t;
  state_t state, state_nxt;
  logic [NUM_CH-1:0] ovr_m, ovr_s, trip_v;
  logic              hit [NUM_CH];
  logic [7:0]        cons [NUM_CH];
  logic [15:0]       per_cnt;
  logic              trip, expire;
  // two-flop synchroniser for the raw flags and registered blanking window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovr_m       <= '0;
      ovr_s       <= '0;
      ovr_I_blank <= 1'b0;
    end else begin
      ovr_m       <= OVR_I;
      ovr_s       <= ovr_m;
      ovr_I_blank <= (pwm_cnt >= B_START) && (pwm_cnt < B_END);
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // per-channel hit capture and consecutive-period count; a retry wipes the history
    always_ff @(posedge clk) begin
      if (!rst_n || clr_fault || expire) begin
        hit[i]  <= 1'b0;
        cons[i] <= '0;
      end else begin
        hit[i] <= (PWM_synch ? 1'b0 : hit[i]) | (ovr_s[i] & ~ovr_I_blank);
        if (PWM_synch) cons[i] <= hit[i] ? ((cons[i] >= TH) ? TH : cons[i] + 8'd1) : 8'd0;
      end
    end
  end
  // a channel trips when the period being closed brings its count to the threshold
  always_comb begin
    trip_v = '0;
    for (int k = 0; k < NUM_CH; k++) trip_v[k] = PWM_synch && hit[k] && (cons[k] >= TH - 8'd1);
  end
  assign trip   = (state == RUN) && (|trip_v);
  assign expire = (RETRY_MODE != 0) && (state == SHTDWN) && PWM_synch && (per_cnt == RP_LAST);
  // next state: clear wins, then trip, then retry expiry
  always_comb begin
    state_nxt = state;
    state_nxt = clr_fault ? RUN :
                trip      ? (((RETRY_MODE != 0) && (retry_cnt == MAX_R)) ? LOCKED : SHTDWN) :
                expire    ? RUN : state;
  end
  // state register, registered outputs, retry bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      OVR_I_shtdwn <= 1'b0;
      locked       <= 1'b0;
      fault_ch     <= '0;
      retry_cnt    <= '0;
      per_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      OVR_I_shtdwn <= state_nxt != RUN;
      locked       <= state_nxt == LOCKED;
      fault_ch     <= clr_fault ? '0 : (fault_ch | (trip ? trip_v : '0));
      retry_cnt    <= clr_fault ? 4'd0 : expire ? retry_cnt + 4'd1 : retry_cnt;
      per_cnt      <= (clr_fault || state != SHTDWN || expire) ? 16'd0 : PWM_synch ? per_cnt + 16'd1 : per_cnt;
    end
  end
endmodule

// File: tb/tb_ovr_i_monitor.sv
// tb_ovr_i_monitor: scoreboard bench for latch-mode and retry-mode monitors
module tb_ovr_i_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        PWM_synch;
  logic [10:0] pwm_cnt;
  logic        rst_a, rst_b, clr_a, clr_b;
  logic [1:0]  ovr_a, ovr_b;
  logic        sh_a, bl_a, lk_a, sh_b, bl_b, lk_b;
  logic [1:0]  fc_a, fc_b;
  logic [3:0]  rc_a, rc_b;
  int n_tests = 0;
  int n_fail  = 0;
  int seq [16] = '{0, 10, 20, 32, 34, 36, 40, 100, 150, 155, 158, 160, 300, 500, 700, 1000};

  ovr_i_monitor #(.NUM_CH(2)) u_lat (
    .clk(clk), .rst_n(rst_a), .PWM_synch(PWM_synch), .pwm_cnt(pwm_cnt), .OVR_I(ovr_a),
    .clr_fault(clr_a), .OVR_I_shtdwn(sh_a), .ovr_I_blank(bl_a), .fault_ch(fc_a),
    .locked(lk_a), .retry_cnt(rc_a));

  ovr_i_monitor #(.NUM_CH(2), .FAULT_THRESH(1), .RETRY_MODE(1), .RETRY_PERIODS(8), .MAX_RETRY(3)) u_ret (
    .clk(clk), .rst_n(rst_b), .PWM_synch(PWM_synch), .pwm_cnt(pwm_cnt), .OVR_I(ovr_b),
    .clr_fault(clr_b), .OVR_I_shtdwn(sh_b), .ovr_I_blank(bl_b), .fault_ch(fc_b),
    .locked(lk_b), .retry_cnt(rc_b));

  typedef struct {
    string      tag;
    bit         dut;
    logic       sh;
    logic [1:0] fc;
    logic       lk;
    logic [3:0] rc;
  } exp_t;
  exp_t sb [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input bit dut, input logic sh, input logic [1:0] fc,
                         input logic lk, input logic [3:0] rc);
    exp_t e;
    e.tag = tag; e.dut = dut; e.sh = sh; e.fc = fc; e.lk = lk; e.rc = rc;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".shtdwn"}, e.dut ? sh_b : sh_a, e.sh);
    chk({e.tag, ".fault_ch"}, e.dut ? fc_b : fc_a, e.fc);
    chk({e.tag, ".locked"}, e.dut ? lk_b : lk_a, e.lk);
    chk({e.tag, ".retry_cnt"}, e.dut ? rc_b : rc_a, e.rc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic synch_cycle(input logic ca, input logic cb);
    pwm_cnt = 11'd0; PWM_synch = 1'b1; clr_a = ca; clr_b = cb; ovr_a = 2'b00;
    step();
    PWM_synch = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
  endtask

  task automatic body(input logic [15:0] mask, input logic [1:0] chs);
    for (int k = 1; k < 16; k++) begin
      pwm_cnt = 11'(seq[k]);
      ovr_a = mask[k] ? chs : 2'b00;
      step();
    end
    ovr_a = 2'b00;
  endtask

  task automatic period(input logic [15:0] mask, input logic [1:0] chs);
    synch_cycle(1'b0, 1'b0);
    body(mask, chs);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    ovr_a = 2'b00; ovr_b = 2'b00; PWM_synch = 1'b0; pwm_cnt = 11'd100;
    step(); step();
    rst_a = 1'b1; rst_b = 1'b1;
    sb_push("reset_lat", 1'b0, 1'b0, 2'b00, 1'b0, 4'd0); sb_check();
    sb_push("reset_ret", 1'b1, 1'b0, 2'b00, 1'b0, 4'd0); sb_check();
    chk("reset_blank", bl_a, 1'b0);
    pwm_cnt = 11'd31;  step(); chk("blank_31", bl_a, 1'b0);
    pwm_cnt = 11'd32;  step(); chk("blank_32", bl_a, 1'b1);
    pwm_cnt = 11'd159; step(); chk("blank_159", bl_a, 1'b1);
    pwm_cnt = 11'd160; step(); chk("blank_160", bl_a, 1'b0);
    for (int p = 0; p < 45; p++) period(16'h01C0, 2'b10);
    sb_push("blanked", 1'b0, 1'b0, 2'b00, 1'b0, 4'd0);
    synch_cycle(1'b0, 1'b0); sb_check();
    body(16'h0000, 2'b00);
    for (int p = 0; p < 29; p++) period(16'h2000, 2'b01);
    sb_push("thr_29", 1'b0, 1'b0, 2'b00, 1'b0, 4'd0);
    synch_cycle(1'b0, 1'b0); sb_check();
    body(16'h0000, 2'b00);
    for (int p = 0; p < 30; p++) period(16'h2000, 2'b01);
    sb_push("thr_30", 1'b0, 1'b1, 2'b01, 1'b0, 4'd0);
    synch_cycle(1'b0, 1'b0); sb_check();
    for (int p = 0; p < 5000; p++) begin
      synch_cycle(1'b0, 1'b0);
      pwm_cnt = 11'd1000;
      step();
    end
    sb_push("latch_hold", 1'b0, 1'b1, 2'b01, 1'b0, 4'd0); sb_check();
    sb_push("latch_clr", 1'b0, 1'b0, 2'b00, 1'b0, 4'd0);
    clr_a = 1'b1; step(); clr_a = 1'b0; sb_check();
    for (int p = 0; p < 30; p++) period(16'h2000, 2'b01);
    sb_push("prio_clr", 1'b0, 1'b0, 2'b00, 1'b0, 4'd0);
    synch_cycle(1'b1, 1'b0); sb_check();
    body(16'h0000, 2'b00);
    for (int p = 0; p < 30; p++) period(16'h2000, 2'b11);
    sb_push("dual_trip", 1'b0, 1'b1, 2'b11, 1'b0, 4'd0);
    synch_cycle(1'b0, 1'b0); sb_check();
    ovr_b = 2'b01;
    body(16'h0000, 2'b00);
    for (int r = 0; r < 4; r++) begin
      sb_push($sformatf("retry_trip%0d", r), 1'b1, 1'b1, 2'b01, r == 3, 4'(r));
      synch_cycle(1'b0, 1'b0); sb_check();
      body(16'h0000, 2'b00);
      if (r < 3) begin
        for (int p = 0; p < 7; p++) period(16'h0000, 2'b00);
        sb_push($sformatf("retry_hold%0d", r), 1'b1, 1'b1, 2'b01, 1'b0, 4'(r)); sb_check();
        sb_push($sformatf("retry_rel%0d", r), 1'b1, 1'b0, 2'b01, 1'b0, 4'(r + 1));
        synch_cycle(1'b0, 1'b0); sb_check();
        body(16'h0000, 2'b00);
      end
    end
    for (int p = 0; p < 100; p++) period(16'h0000, 2'b00);
    sb_push("locked_hold", 1'b1, 1'b1, 2'b01, 1'b1, 4'd3); sb_check();
    pwm_cnt = 11'd100; rst_b = 1'b0; step(); rst_b = 1'b1;
    sb_push("reset_locked", 1'b1, 1'b0, 2'b00, 1'b0, 4'd0); sb_check();
    chk("reset_locked.blank", bl_b, 1'b0);
    ovr_b = 2'b00;
    period(16'h0000, 2'b00);
    sb_push("post_reset_quiet", 1'b1, 1'b0, 2'b00, 1'b0, 4'd0);
    synch_cycle(1'b0, 1'b0); sb_check();
    ovr_b = 2'b01;
    body(16'h0000, 2'b00);
    sb_push("post_reset_trip", 1'b1, 1'b1, 2'b01, 1'b0, 4'd0);
    synch_cycle(1'b0, 1'b0); sb_check();
    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ovr_i_monitor.md
# ovr_i_monitor

Parametrised multi-channel over-current monitor that sits between the motor-driver current-sense comparators and the PWM/drive stage. Each channel's over-current flag is synchronised and ignored inside a programmable blanking window around the PWM switching edge. Faults are qualified over consecutive PWM periods. A common shutdown is raised once any channel exceeds its fault threshold. Recovery uses either latch-until-cleared or a bounded auto-retry mode, extending the fixed two-channel, latch-only over-current shutdown in the current drive path.

## Interface
- NUM_CH, 2, number of monitored motor channels (1..8)
- PWM_W, 11, width of the PWM period counter
- BLANK_START, 32, first pwm_cnt value inside the blanking window
- BLANK_END, 160, first pwm_cnt value after the blanking window (exclusive; BLANK_END > BLANK_START)
- FAULT_THRESH, 30, consecutive faulted PWM periods that trigger shutdown (1..255)
- RETRY_MODE, 0, 0 = latch until clr_fault; 1 = auto-retry
- RETRY_PERIODS, 1024, PWM periods held in shutdown before a retry (1..65535)
- MAX_RETRY, 3, retries allowed before permanent lock (1..15)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- PWM_synch  in  1  one-cycle pulse marking the start of each PWM period
- pwm_cnt  in  PWM_W  current PWM period counter value
- OVR_I  in  NUM_CH  raw asynchronous over-current flags, active high
- clr_fault  in  1  one-cycle pulse that clears every fault state and the retry count
- OVR_I_shtdwn  out  1  registered; high forces all PWM outputs low
- ovr_I_blank  out  1  registered; high while pwm_cnt is inside the blanking window
- fault_ch  out  NUM_CH  sticky per-channel fault cause; set on the channel that tripped
- locked  out  1  high in the LOCKED state
- retry_cnt  out  4  number of retries taken since the last reset or clr_fault

## Operation
- Synchroniser: each OVR_I bit passes through a 2-flop synchroniser to produce ovr_s[i].
- Blanking: ovr_I_blank is registered from (pwm_cnt >= BLANK_START && pwm_cnt < BLANK_END).
- Per-channel hit flag: hit[i] is set on any cycle where ovr_s[i] && !ovr_I_blank.
- Period evaluation, on each PWM_synch cycle:
  - if hit[i] is set, cons[i] increments, saturating at FAULT_THRESH; otherwise cons[i] clears.
  - hit[i] is then cleared. A hit in the PWM_synch cycle itself counts toward the new period.
- Trip: any cons[i] reaching FAULT_THRESH while in state RUN is a trip.
  - fault_ch[i] is ORed in for every channel that reached the threshold.
- State machine (states RUN, SHTDWN, LOCKED):
  - RUN to SHTDWN on trip. In RETRY_MODE=1, if retry_cnt == MAX_RETRY, the trip goes directly to LOCKED instead.
  - SHTDWN with RETRY_MODE=0: held until clr_fault.
  - SHTDWN with RETRY_MODE=1: an internal 16-bit period counter counts PWM_synch pulses. On reaching RETRY_PERIODS the block returns to RUN, retry_cnt increments, cons and hit clear, and fault_ch is retained.
  - LOCKED: held until clr_fault.
- OVR_I_shtdwn is high in SHTDWN and LOCKED.
- Cons and hit counters keep running in SHTDWN and LOCKED but cannot trip.
- clr_fault, from any state:
  - next state RUN;
  - cons, hit, fault_ch, retry_cnt and the period counter all clear;
  - clr_fault has priority over a trip or retry expiry in the same cycle.

## Timing
- Reset (rst_n low at a clk edge): state RUN; OVR_I_shtdwn=0, ovr_I_blank=0, fault_ch=0, locked=0, retry_cnt=0; synchronisers, cons, hit and period counter all cleared.
- Reset mid-shutdown behaves identically to reset at any other time.
- OVR_I to ovr_s: 2 clk. ovr_I_blank lags pwm_cnt by 1 clk.
- Trip latency: OVR_I_shtdwn and fault_ch update on the clk edge after the PWM_synch cycle in which cons reaches FAULT_THRESH.
- Retry release: OVR_I_shtdwn falls on the clk edge after the RETRY_PERIODS-th PWM_synch counted in SHTDWN.
- Simultaneous trips on several channels set every matching fault_ch bit in the same cycle.
- FAULT_THRESH=1: a single unblanked hit trips at the next PWM_synch.

## Test plan
- Blanking: NUM_CH=2, FAULT_THRESH=30. OVR_I[1] is pulsed only while pwm_cnt is in [40,150] for 45 periods. Required: OVR_I_shtdwn stays 0 and fault_ch=2'b00.
- Threshold: OVR_I[0] high at pwm_cnt=500 for 29 consecutive periods, then one clean period, then 30 consecutive periods. Required: no shutdown after the first 29. Shutdown is set 1 clk after the 30th PWM_synch of the second run, with fault_ch=2'b01.
- Latch mode: after the right channel trips with RETRY_MODE=0, 5000 periods are run with OVR_I low. Required: OVR_I_shtdwn stays 1. A clr_fault pulse drops OVR_I_shtdwn 1 clk later with fault_ch=0.
- Retry mode: RETRY_MODE=1, RETRY_PERIODS=8, MAX_RETRY=3, with a persistent unblanked fault. Required:
  - three release/re-trip cycles, with retry_cnt stepping 1, 2, 3;
  - the 4th trip enters LOCKED (locked=1);
  - after that, shutdown holds for 100 periods.
- Priority: clr_fault is asserted in the same cycle as the tripping PWM_synch. Required: state RUN, OVR_I_shtdwn=0, fault_ch=0.
- Reset: rst_n is pulled low for 1 clk while LOCKED. Required: all outputs return to 0 the next clk, and fresh trips again follow the FAULT_THRESH count.
